seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; rst is asynchronous, active-high; clock is clk.
REQ-006 SHALL have port en  input  1  display enable; 0 blanks the display and freezes all counters.
REQ-007 SHALL have port load  input  1  single-cycle strobe capturing data, dp_mask, blink_mask, lz_en into the pending register.
REQ-008 SHALL have port data  input  4*NDIG  hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost.
REQ-009 SHALL have port dp_mask  input  NDIG  1 = light the decimal point of digit i.
REQ-010 SHALL have port blink_mask  input  NDIG  1 = digit i blinks.
REQ-011 SHALL have port lz_en  input  1  1 = leading-zero suppression on.
REQ-012 SHALL have port seg  output  8  active-low segments, seg[7]=dp, seg[6:0]=gfedcba.
REQ-013 SHALL have port an  output  NDIG  active-low digit enables, one-hot-low or all ones.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-015 SHALL count a prescaler 0..DIV-1 while en=1; slot tick when prescaler=DIV-1, prescaler then wraps to 0.
REQ-016 SHALL advance digit index 0..NDIG-1 on each tick, wrapping NDIG-1->0; the wrapping tick is the frame boundary.
REQ-017 SHALL pulse frame_done for exactly the cycle after the frame-boundary tick.
REQ-018 SHALL update the active register from the pending register only at the frame boundary (no mid-frame tearing).
REQ-019 SHALL, when load coincides with the frame-boundary tick, commit the newly presented inputs directly to active.
REQ-020 SHALL register seg and an; both reflect the current index one cycle after the index changes.
REQ-021 SHALL hold an all ones for the first cycle of every digit slot (dead-time anti-ghosting); seg already shows the new digit.
REQ-022 SHALL decode nibbles 0-F active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 SHALL, with lz_en=1, blank (an high for that slot) every zero digit above the highest nonzero digit; digit 0 never suppressed; all-zero value shows a single 0.
REQ-024 SHALL toggle a blink phase every BLINK_FRAMES frame boundaries; in phase 1, digits with blink_mask=1 are blanked.
REQ-025 SHALL drive seg[7]=0 for digit i only when dp_mask[i]=1 and the digit is not blanked.
REQ-026 SHALL, while en=0, drive an all ones and seg all ones from the next cycle, freezing prescaler, index and blink state; load still captures into pending.
REQ-027 SHALL resume from the frozen state when en returns to 1, starting with a dead-time cycle.

Reset
REQ-028 SHALL on rst clear prescaler, index, blink counter, blink phase, pending and active registers to 0.
REQ-029 SHALL on rst drive an all ones, seg all ones, frame_done 0, immediately and asynchronously.
REQ-030 SHALL, on release of rst, begin digit 0 slot with the dead-time cycle.

Structure
REQ-031 SHALL place the 16-entry hex-to-segment table, the blank code 7'b1111111 and polarity constants in shared package seg_pkg.
REQ-032 SHALL isolate nibble decoding in one combinational sub-module seg_hex_decode; all sequencing remains in seg_scan_driver.

Verification (NDIG=4, DIV=4, BLINK_FRAMES=2)
REQ-033 SHALL check: load data=16'h1234, en=1 -> after first commit an cycles 1110,1101,1011,0111, each digit held 3 cycles after 1 dead cycle, seg 0011001/0110000/0100100/1111001; frame_done every 16 cycles.
REQ-034 SHALL check: data=16'h00A0, lz_en=1 -> digits 3,2 blanked, digit1=0001000, digit0=1000000; data=16'h0000 -> only digit 0 lit.
REQ-035 SHALL check: load 16'hFFFF mid-frame -> old value completes the frame, 1110 slot of next frame shows 0001110.
REQ-036 SHALL check: blink_mask=4'b0001, dp_mask=4'b0100 -> digit 0 dark every other 2-frame window; digit 2 seg[7]=0 only.
REQ-037 SHALL check: en=0 mid-slot for 10 cycles -> an=1111, seg=8'hFF, resumes same index with dead cycle; rst asserted mid-frame -> an=1111 same cycle, index 0 after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
//   seg7_t      : one digit's active-low gfedcba segment vector
//   HEX_TABLE   : nibble 0-F to segment pattern, indexed by the nibble value
//   SEG_BLANK   : all segments dark
//   SEG_ON/OFF  : segment polarity (active-low)
//   AN_ON/OFF   : digit-enable polarity (active-low)
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;

    // Leftmost entry is nibble F, rightmost is nibble 0.
    localparam seg7_t [15:0] HEX_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-content bus of the scan driver.
//   load       : single-cycle strobe capturing the fields below
//   data       : hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp_mask    : 1 = light the decimal point of digit i
//   blink_mask : 1 = digit i blinks
//   lz_en      : 1 = leading-zero suppression on
// master drives the bus, slave (the driver) receives it.
interface seg_scan_driver_if #(
    parameter int NDIG = 4
);
    logic                load;
    logic [4*NDIG-1:0]   data;
    logic [NDIG-1:0]     dp_mask;
    logic [NDIG-1:0]     blink_mask;
    logic                lz_en;

    modport master (output load, data, dp_mask, blink_mask, lz_en);
    modport slave  (input  load, data, dp_mask, blink_mask, lz_en);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : value 0-F
//   segs   : gfedcba, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      segs
);

    assign segs = HEX_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment display driver.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : 1 = scan; 0 = blank display and freeze all counters
//   bus        : display-content bus (load/data/dp_mask/blink_mask/lz_en)
//   seg        : registered active-low segments, seg[7]=dp, seg[6:0]=gfedcba
//   an         : registered active-low digit enables (one-hot-low or all ones)
//   frame_done : one-cycle pulse the cycle after each frame wrap
// Content is double-buffered: load fills a pending register that is copied to
// the displayed register only at the frame boundary, so a frame never mixes
// old and new values.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    seg_scan_driver_if.slave       bus,
    output logic [7:0]             seg,
    output logic [NDIG-1:0]        an,
    output logic                   frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(NDIG);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]      presc;
    logic [IW-1:0]      idx;
    logic [BW-1:0]      blink_cnt;
    logic               blink_phase;
    logic               en_q;

    logic [4*NDIG-1:0]  pend_data;
    logic [NDIG-1:0]    pend_dp;
    logic [NDIG-1:0]    pend_blink;
    logic               pend_lz;

    logic [4*NDIG-1:0]  act_data;
    logic [NDIG-1:0]    act_dp;
    logic [NDIG-1:0]    act_blink;
    logic               act_lz;

    logic               tick;
    logic               boundary;
    logic [3:0]         cur_nib;
    seg7_t              hex_seg;
    logic [IW-1:0]      hi_idx;
    logic               blank;
    logic [7:0]         seg_next;
    logic [NDIG-1:0]    an_slot;

    assign tick     = en && (presc == PRESC_LAST);
    assign boundary = tick && (idx == IDX_LAST);
    assign cur_nib  = act_data[{idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .segs   (hex_seg)
    );

    // Highest digit index holding a nonzero nibble; 0 when the value is zero,
    // so digit 0 is never suppressed.
    always_comb begin
        hi_idx = '0;
        for (int unsigned i = 1; i < NDIG; i++) begin
            if (act_data[4*i +: 4] != 4'h0) begin
                hi_idx = IW'(i);
            end
        end
    end

    always_comb begin
        blank = (act_lz && (idx > hi_idx)) || (blink_phase && act_blink[idx]);

        seg_next = {SEG_OFF, SEG_BLANK};
        an_slot  = {NDIG{AN_OFF}};
        if (!blank) begin
            seg_next     = {(act_dp[idx] ? SEG_ON : SEG_OFF), hex_seg};
            an_slot[idx] = AN_ON;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            en_q        <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_blink  <= '0;
            pend_lz     <= 1'b0;
            act_data    <= '0;
            act_dp      <= '0;
            act_blink   <= '0;
            act_lz      <= 1'b0;
            seg         <= '1;
            an          <= '1;
            frame_done  <= 1'b0;
        end else begin
            en_q       <= en;
            frame_done <= boundary;

            if (bus.load) begin
                pend_data  <= bus.data;
                pend_dp    <= bus.dp_mask;
                pend_blink <= bus.blink_mask;
                pend_lz    <= bus.lz_en;
            end

            if (en) begin
                seg <= seg_next;
                // Dead time on the first cycle of each slot and on the cycle
                // that resumes scanning after a disable.
                an  <= ((presc == '0) || !en_q) ? '1 : an_slot;

                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end

                if (boundary) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end

                    // A load on the boundary bypasses pending so it is not
                    // lost for a whole frame.
                    if (bus.load) begin
                        act_data  <= bus.data;
                        act_dp    <= bus.dp_mask;
                        act_blink <= bus.blink_mask;
                        act_lz    <= bus.lz_en;
                    end else begin
                        act_data  <= pend_data;
                        act_dp    <= pend_dp;
                        act_blink <= pend_blink;
                        act_lz    <= pend_lz;
                    end
                end
            end else begin
                seg <= '1;
                an  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (NDIG=4, DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;

    localparam int NDIG = 4;
    localparam int DIV  = 4;
    localparam int BF   = 2;
    localparam int FRAME = NDIG * DIV;

    logic clk;
    logic rst;
    logic en;
    logic [7:0]      seg;
    logic [NDIG-1:0] an;
    logic            frame_done;

    seg_scan_driver_if #(.NDIG(NDIG)) bus ();

    seg_scan_driver #(
        .NDIG         (NDIG),
        .DIV          (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic check_on = 1'b0;

    task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Model: T counts enabled clock edges since reset; slot position, digit,
    // frame number and blink phase all follow from it arithmetically.
    int               T = 0;
    logic             en_prev = 1'b0;
    logic [15:0]      pend_data = '0, act_data = '0;
    logic [3:0]       pend_dp = '0, act_dp = '0, pend_bl = '0, act_bl = '0;
    logic             pend_lz = 1'b0, act_lz = 1'b0;
    logic [7:0]       exp_seg = 8'hFF;
    logic [3:0]       exp_an = 4'hF;
    logic             exp_fd = 1'b0;

    always @(posedge clk or posedge rst) begin
        int p, k, phase;
        logic bnd, off;
        if (rst) begin
            T = 0; en_prev = 1'b0;
            pend_data = '0; act_data = '0; pend_dp = '0; act_dp = '0;
            pend_bl = '0; act_bl = '0; pend_lz = 1'b0; act_lz = 1'b0;
            exp_seg = 8'hFF; exp_an = 4'hF; exp_fd = 1'b0;
        end else begin
            p     = T % DIV;
            k     = (T / DIV) % NDIG;
            phase = ((T / FRAME) / BF) % 2;
            bnd   = en && (p == DIV - 1) && (k == NDIG - 1);
            if (en) begin
                // Leading zero: this digit and every digit above it are zero.
                off = (act_lz && k > 0 && ((act_data >> (4 * k)) == 16'h0))
                   || (phase == 1 && act_bl[k]);
                exp_seg = off ? 8'hFF : {~act_dp[k], hex7(act_data[4*k +: 4])};
                exp_an  = (off || p == 0 || !en_prev) ? 4'hF : ~(4'b0001 << k);
            end else begin
                exp_seg = 8'hFF;
                exp_an  = 4'hF;
            end
            exp_fd = bnd;
            if (bnd) begin
                if (bus.load) begin
                    act_data = bus.data; act_dp = bus.dp_mask;
                    act_bl = bus.blink_mask; act_lz = bus.lz_en;
                end else begin
                    act_data = pend_data; act_dp = pend_dp;
                    act_bl = pend_bl; act_lz = pend_lz;
                end
            end
            if (bus.load) begin
                pend_data = bus.data; pend_dp = bus.dp_mask;
                pend_bl = bus.blink_mask; pend_lz = bus.lz_en;
            end
            if (en) T++;
            en_prev = en;
        end
    end

    always @(negedge clk) begin
        if (check_on && !rst) begin
            chk("model_seg", seg, exp_seg);
            chk("model_an", 8'(an), 8'(exp_an));
            chk("model_fd", 8'(frame_done), 8'(exp_fd));
        end
    end

    task automatic load_val(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz);
        bus.data = d; bus.dp_mask = dp; bus.blink_mask = bl; bus.lz_en = lz;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL wait_fd actual=no_pulse required=pulse at %0t", $time);
        end
    endtask

    // Check one full frame starting right after a frame_done pulse.
    task automatic check_frame(input string tag, input logic [3:0][3:0] an_s,
                               input logic [3:0][7:0] seg_s);
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            chk({tag, "_an"}, 8'(an), (j % DIV == 0) ? 8'h0F : 8'(an_s[j / DIV]));
            chk({tag, "_seg"}, seg, seg_s[j / DIV]);
            chk({tag, "_fd"}, 8'(frame_done), (j == FRAME - 1) ? 8'h01 : 8'h00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0;
        bus.load = 1'b0; bus.data = '0; bus.dp_mask = '0; bus.blink_mask = '0; bus.lz_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_an", 8'(an), 8'h0F);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_fd", 8'(frame_done), 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        check_on = 1'b1;
        load_val(16'h1234, 4'b0000, 4'b0000, 1'b0);
        wait_fd();
        check_frame("f1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                             {8'hF9, 8'hA4, 8'hB0, 8'h99});

        load_val(16'h00A0, 4'b0000, 4'b0000, 1'b1);
        wait_fd();
        check_frame("lz00A0", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                              {8'hFF, 8'hFF, 8'h88, 8'hC0});

        load_val(16'h0000, 4'b0000, 4'b0000, 1'b1);
        wait_fd();
        check_frame("lz0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                              {8'hFF, 8'hFF, 8'hFF, 8'hC0});

        repeat (5) @(negedge clk);
        load_val(16'hFFFF, 4'b0000, 4'b0000, 1'b0);
        wait_fd();
        check_frame("fFFFF", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                             {8'h8E, 8'h8E, 8'h8E, 8'h8E});

        // Frame 10 falls in blink phase 0, frame 11 in phase 1.
        load_val(16'h1234, 4'b0100, 4'b0001, 1'b0);
        wait_fd();
        check_frame("blink_on", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                                {8'hF9, 8'h24, 8'hB0, 8'h99});
        check_frame("blink_off", {4'b0111, 4'b1011, 4'b1101, 4'b1111},
                                 {8'hF9, 8'h24, 8'hB0, 8'hFF});

        // Disable in the middle of digit 1's slot.
        repeat (6) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("dis_an", 8'(an), 8'h0F);
            chk("dis_seg", seg, 8'hFF);
        end
        en = 1'b1;
        @(negedge clk);
        chk("resume_dead_an", 8'(an), 8'h0F);
        chk("resume_dead_seg", seg, 8'hB0);
        @(negedge clk);
        chk("resume_an", 8'(an), 8'h0D);
        chk("resume_seg", seg, 8'hB0);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_an", 8'(an), 8'h0F);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_fd", 8'(frame_done), 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dead_an", 8'(an), 8'h0F);
        chk("post_rst_dead_seg", seg, 8'hC0);
        @(negedge clk);
        chk("post_rst_an", 8'(an), 8'h0E);
        chk("post_rst_seg", seg, 8'hC0);

        repeat (2 * FRAME) @(negedge clk);
        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
